// File: rtl/adc_poller_pkg.sv
// Shared monitor definitions for the XADC poller: DRP channel map, sweep size and FSM encodings.
package adc_poller_pkg;

    localparam int unsigned NUM_CH  = 7;
    localparam logic [2:0]  CH_LAST = 3'(NUM_CH - 1);

    localparam logic [6:0] ADDR_TEMP   = 7'h00;
    localparam logic [6:0] ADDR_VCCINT = 7'h01;
    localparam logic [6:0] ADDR_VCCAUX = 7'h02;
    localparam logic [6:0] ADDR_BPLSSW = 7'h14;
    localparam logic [6:0] ADDR_P4SW   = 7'h1C;
    localparam logic [6:0] ADDR_P3V3IO = 7'h15;
    localparam logic [6:0] ADDR_MTEMP  = 7'h1D;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_READ, SEQ_COMMIT} seq_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT} rd_state_e;

    function automatic logic [6:0] ch_addr(input logic [2:0] ch);
        case (ch)
            3'd0:    return ADDR_TEMP;
            3'd1:    return ADDR_VCCINT;
            3'd2:    return ADDR_VCCAUX;
            3'd3:    return ADDR_BPLSSW;
            3'd4:    return ADDR_P4SW;
            3'd5:    return ADDR_P3V3IO;
            3'd6:    return ADDR_MTEMP;
            default: return ADDR_TEMP;
        endcase
    endfunction

endpackage

// File: rtl/adc_poller_drp_reader.sv
// Single DRP read transaction: one-cycle strobe, bounded wait for drdy, data/timeout report.
module adc_poller_drp_reader
    import adc_poller_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  addr,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic        done,
    output logic        timed_out,
    output logic [15:0] data
);
    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    rd_state_e     st;
    logic [CW-1:0] cnt;
    logic          at_limit;

    // Data arriving on the final wait cycle wins over the timeout.
    assign at_limit  = (cnt == LIM);
    assign done      = (st == RD_WAIT) && (drp_drdy || at_limit);
    assign timed_out = (st == RD_WAIT) && !drp_drdy && at_limit;
    assign data      = drp_do;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= RD_IDLE;
            drp_den   <= 1'b0;
            drp_daddr <= '0;
            cnt       <= '0;
        end else begin
            drp_den <= 1'b0;
            case (st)
                RD_IDLE: begin
                    if (start) begin
                        st        <= RD_REQ;
                        drp_den   <= 1'b1;
                        drp_daddr <= addr;
                    end
                end
                RD_REQ: begin
                    st  <= RD_WAIT;
                    cnt <= '0;
                end
                RD_WAIT: begin
                    if (done) begin
                        if (start) begin
                            st        <= RD_REQ;
                            drp_den   <= 1'b1;
                            drp_daddr <= addr;
                        end else begin
                            st <= RD_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: st <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/adc_poller.sv
// XADC DRP poller: on each end-of-sequence sweeps seven channels into a shadow bank,
// then commits the whole bank on one edge so readers never see a mixed sample set.
module adc_poller
    import adc_poller_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eos,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [15:0] adc_temp,
    output logic [15:0] adc_vccint,
    output logic [15:0] adc_vccaux,
    output logic [15:0] adc_bplssw,
    output logic [15:0] adc_p4sw,
    output logic [15:0] adc_p3v3io,
    output logic [15:0] adc_mtemp,
    output logic        sample_valid,
    output logic [7:0]  timeout_count
);
    seq_state_e  state;
    logic        pending;
    logic [2:0]  ch;
    logic        last_ch;
    logic [15:0] shadow [NUM_CH];
    logic [15:0] bank   [NUM_CH];

    logic        rd_start;
    logic [6:0]  rd_addr;
    logic        rd_done;
    logic        rd_timed_out;
    logic [15:0] rd_data;

    assign drp_dwe = 1'b0;
    assign drp_di  = '0;
    assign last_ch = (ch == CH_LAST);

    // The next request is launched on the same edge the previous read completes,
    // so back-to-back channels cost exactly 1+L cycles each.
    always_comb begin
        rd_start = 1'b0;
        rd_addr  = ch_addr(3'd0);
        if (state == SEQ_IDLE && (eos || pending)) begin
            rd_start = 1'b1;
        end else if (state == SEQ_READ && rd_done && !last_ch) begin
            rd_start = 1'b1;
            rd_addr  = ch_addr(ch + 3'd1);
        end
    end

    adc_poller_drp_reader #(.TIMEOUT(TIMEOUT)) u_reader (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (rd_start),
        .addr      (rd_addr),
        .drp_drdy  (drp_drdy),
        .drp_do    (drp_do),
        .drp_den   (drp_den),
        .drp_daddr (drp_daddr),
        .done      (rd_done),
        .timed_out (rd_timed_out),
        .data      (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEQ_IDLE;
            pending       <= 1'b0;
            ch            <= '0;
            sample_valid  <= 1'b0;
            timeout_count <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                bank[i]   <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (eos && state != SEQ_IDLE) pending <= 1'b1;
            case (state)
                SEQ_IDLE: begin
                    if (eos || pending) begin
                        state   <= SEQ_READ;
                        ch      <= '0;
                        pending <= 1'b0;
                    end
                end
                SEQ_READ: begin
                    if (rd_done) begin
                        if (!rd_timed_out) shadow[ch] <= rd_data;
                        else if (timeout_count != '1) timeout_count <= timeout_count + 8'd1;
                        if (last_ch) state <= SEQ_COMMIT;
                        else         ch    <= ch + 3'd1;
                    end
                end
                SEQ_COMMIT: begin
                    bank         <= shadow;
                    sample_valid <= 1'b1;
                    state        <= SEQ_IDLE;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    assign adc_temp   = bank[0];
    assign adc_vccint = bank[1];
    assign adc_vccaux = bank[2];
    assign adc_bplssw = bank[3];
    assign adc_p4sw   = bank[4];
    assign adc_p3v3io = bank[5];
    assign adc_mtemp  = bank[6];

endmodule
